// File: rtl/hawk_tbl_rd_engine.sv
// hawk_tbl_rd_engine
// Resolves 1-based ATT / TOL (list) entry ids into cacheline reads over an
// AXI read channel. One line buffer per table type caches the last line that
// was read successfully, so neighbouring ids are served without touching AXI.
//
// Ports
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_*                : lookup request (type 0=ATT, 1=TOL; 1-based id)
//   inv_i                : invalidate both line buffers
//   ar*/arlen_o          : AXI AR channel (single-beat bursts)
//   r*                   : AXI R channel
//   rsp_*                : lookup result (entry, full line, error, hit flag)

// Fallback table bases when the platform header has not defined them.
`ifndef HAWK_ATT_START
`define HAWK_ATT_START 64'h0000_0000_8000_0000
`endif
`ifndef HAWK_LIST_START
`define HAWK_LIST_START 64'h0000_0000_9000_0000
`endif

module hawk_tbl_rd_engine #(
  parameter int unsigned AXI_ADDR_W = 64,
  parameter int unsigned AXI_DATA_W = 512,
  parameter int unsigned ATT_ENT_W  = 64,
  parameter int unsigned LST_ENT_W  = 128,
  parameter int unsigned ID_W       = 20,
  parameter logic [AXI_ADDR_W-1:0] ATT_BASE = `HAWK_ATT_START,
  parameter logic [AXI_ADDR_W-1:0] LST_BASE = `HAWK_LIST_START,
  localparam int unsigned ENT_MAX_W = (ATT_ENT_W > LST_ENT_W) ? ATT_ENT_W : LST_ENT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_type_i,
  input  logic [ID_W-1:0]       req_id_i,
  input  logic                  inv_i,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [AXI_ADDR_W-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [AXI_DATA_W-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_type_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [ENT_MAX_W-1:0]  rsp_entry_o,
  output logic [AXI_DATA_W-1:0] rsp_line_o,
  output logic                  rsp_err_o,
  output logic                  rsp_hit_o
);

  localparam int unsigned ATT_EPL     = AXI_DATA_W / ATT_ENT_W;
  localparam int unsigned LST_EPL     = AXI_DATA_W / LST_ENT_W;
  localparam int unsigned ATT_EPL_LOG = $clog2(ATT_EPL);
  localparam int unsigned LST_EPL_LOG = $clog2(LST_EPL);
  localparam int unsigned ATT_ENT_LOG = $clog2(ATT_ENT_W);
  localparam int unsigned LST_ENT_LOG = $clog2(LST_ENT_W);
  localparam int unsigned LINE_B_LOG  = $clog2(AXI_DATA_W / 8);
  localparam int unsigned BIT_W       = $clog2(AXI_DATA_W);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // Entry extraction: slot 0 sits at the line LSBs for both table types.
  function automatic logic [ENT_MAX_W-1:0] pick_entry(
    input logic [AXI_DATA_W-1:0] line,
    input logic                  typ,
    input logic [BIT_W-1:0]      slot
  );
    logic [ENT_MAX_W-1:0] ent;
    if (typ) begin
      ent = ENT_MAX_W'(line[(slot << LST_ENT_LOG) +: LST_ENT_W]);
    end else begin
      ent = ENT_MAX_W'(line[(slot << ATT_ENT_LOG) +: ATT_ENT_W]);
    end
    return ent;
  endfunction

  state_e                state_q, state_d;
  logic                  type_q, type_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       tag_q, tag_d;
  logic [BIT_W-1:0]      slot_q, slot_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic [ENT_MAX_W-1:0]  entry_q, entry_d;
  logic [AXI_DATA_W-1:0] line_q, line_d;
  logic                  err_q, err_d;
  logic                  hit_q, hit_d;
  logic [1:0]            buf_vld_q, buf_vld_d;
  logic [ID_W-1:0]       buf_tag_q [2];
  logic [ID_W-1:0]       buf_tag_d [2];
  logic [AXI_DATA_W-1:0] buf_line_q [2];
  logic [AXI_DATA_W-1:0] buf_line_d [2];

  logic [ID_W-1:0]       req_idm1_s;
  logic [ID_W-1:0]       req_line_s;
  logic [BIT_W-1:0]      req_slot_s;
  logic [AXI_ADDR_W-1:0] req_addr_s;
  logic                  req_hit_s;

  // Decode the incoming request: line index, slot, AXI address, buffer hit.
  always_comb begin
    req_idm1_s = req_id_i - ID_W'(1);
    if (req_type_i) begin
      req_line_s = req_idm1_s >> LST_EPL_LOG;
      req_slot_s = BIT_W'(req_idm1_s & ID_W'(LST_EPL - 1));
      req_addr_s = LST_BASE + (AXI_ADDR_W'(req_line_s) << LINE_B_LOG);
    end else begin
      req_line_s = req_idm1_s >> ATT_EPL_LOG;
      req_slot_s = BIT_W'(req_idm1_s & ID_W'(ATT_EPL - 1));
      req_addr_s = ATT_BASE + (AXI_ADDR_W'(req_line_s) << LINE_B_LOG);
    end
    // A coincident invalidate must force the miss path.
    req_hit_s = buf_vld_q[req_type_i] & (buf_tag_q[req_type_i] == req_line_s) & ~inv_i;
  end

  // Next-state and datapath updates for the lookup FSM and line buffers.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    id_d       = id_q;
    tag_d      = tag_q;
    slot_d     = slot_q;
    araddr_d   = araddr_q;
    entry_d    = entry_q;
    line_d     = line_q;
    err_d      = err_q;
    hit_d      = hit_q;
    buf_vld_d  = buf_vld_q;
    buf_tag_d  = buf_tag_q;
    buf_line_d = buf_line_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          type_d = req_type_i;
          id_d   = req_id_i;
          tag_d  = req_line_s;
          slot_d = req_slot_s;
          if (req_id_i == '0) begin
            err_d   = 1'b1;
            hit_d   = 1'b0;
            entry_d = '0;
            line_d  = '0;
            state_d = ST_RSP;
          end else if (req_hit_s) begin
            err_d   = 1'b0;
            hit_d   = 1'b1;
            line_d  = buf_line_q[req_type_i];
            entry_d = pick_entry(buf_line_q[req_type_i], req_type_i, req_slot_s);
            state_d = ST_RSP;
          end else begin
            err_d    = 1'b0;
            hit_d    = 1'b0;
            araddr_d = req_addr_s;
            state_d  = ST_AR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (arready_i) begin
          state_d = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (rvalid_i) begin
          line_d  = rdata_i;
          entry_d = pick_entry(rdata_i, type_q, slot_q);
          hit_d   = 1'b0;
          state_d = ST_RSP;
          if (rresp_i == RESP_OKAY) begin
            err_d = 1'b0;
            // An invalidate landing on the capture cycle leaves the buffer empty.
            if (!inv_i) begin
              buf_vld_d[type_q]  = 1'b1;
              buf_tag_d[type_q]  = tag_q;
              buf_line_d[type_q] = rdata_i;
            end else begin
              buf_vld_d[type_q] = 1'b0;
            end
          end else begin
            err_d             = 1'b1;
            buf_vld_d[type_q] = 1'b0;
          end
        end else begin
          state_d = ST_R;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Invalidate wins over any fill in the same cycle, in every state.
    buf_vld_d = buf_vld_d & {2{~inv_i}};
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      type_q     <= 1'b0;
      id_q       <= '0;
      tag_q      <= '0;
      slot_q     <= '0;
      araddr_q   <= '0;
      entry_q    <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
      buf_vld_q  <= 2'b00;
      buf_tag_q  <= '{default: '0};
      buf_line_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      id_q       <= id_d;
      tag_q      <= tag_d;
      slot_q     <= slot_d;
      araddr_q   <= araddr_d;
      entry_q    <= entry_d;
      line_q     <= line_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      buf_vld_q  <= buf_vld_d;
      buf_tag_q  <= buf_tag_d;
      buf_line_q <= buf_line_d;
    end
  end

  // Handshake outputs are pure state decodes, so req_ready_o never depends
  // combinationally on arready_i or rsp_ready_i.
  assign req_ready_o = (state_q == ST_IDLE);
  assign arvalid_o   = (state_q == ST_AR);
  assign rready_o    = (state_q == ST_R);
  assign rsp_valid_o = (state_q == ST_RSP);
  assign araddr_o    = araddr_q;
  assign arlen_o     = 8'd0;
  assign rsp_type_o  = type_q;
  assign rsp_id_o    = id_q;
  assign rsp_entry_o = entry_q;
  assign rsp_line_o  = line_q;
  assign rsp_err_o   = err_q;
  assign rsp_hit_o   = hit_q;

endmodule

// File: tb/tb_hawk_tbl_rd_engine.sv
`timescale 1ns/1ps
module tb_hawk_tbl_rd_engine;

  localparam int          AW    = 64;
  localparam int          DW    = 512;
  localparam int          IW    = 20;
  localparam logic [63:0] ATT_B = 64'h0000_0001_0000_0000;
  localparam logic [63:0] LST_B = 64'h0000_0002_0000_0000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready, req_type, inv;
  logic [IW-1:0]  req_id;
  logic           arvalid, arready, rvalid, rready;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rsp_valid, rsp_ready, rsp_type, rsp_err, rsp_hit;
  logic [IW-1:0]  rsp_id;
  logic [127:0]   rsp_entry;
  logic [DW-1:0]  rsp_line;

  int n_vec = 0;
  int n_err = 0;

  // reference model of the two line buffers
  bit           m_vld [2];
  int           m_tag [2];
  logic [511:0] m_line [2];

  always #5 clk = ~clk;

  hawk_tbl_rd_engine #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .ATT_ENT_W(64), .LST_ENT_W(128),
    .ID_W(IW), .ATT_BASE(ATT_B), .LST_BASE(LST_B)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_type_i(req_type),
    .req_id_i(req_id), .inv_i(inv),
    .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arlen_o(arlen),
    .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rresp_i(rresp),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_type_o(rsp_type),
    .rsp_id_o(rsp_id), .rsp_entry_o(rsp_entry), .rsp_line_o(rsp_line),
    .rsp_err_o(rsp_err), .rsp_hit_o(rsp_hit)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int epl(input bit t);
    return t ? 4 : 8;
  endfunction

  function automatic int ent_w(input bit t);
    return t ? 128 : 64;
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [511:0] exp_entry(input logic [511:0] line, input bit t, input int id);
    logic [511:0] mask;
    int slot;
    slot = (id - 1) % epl(t);
    mask = '1;
    mask = mask >> (512 - ent_w(t));
    return (line >> (slot * ent_w(t))) & mask;
  endfunction

  task automatic model_clear();
    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
  endtask

  task automatic check_rsp(input bit t, input int id, input logic [511:0] e_ent,
                           input logic [511:0] e_line, input bit e_err, input bit e_hit);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_type", rsp_type, t);
    chk("rsp_id", rsp_id, id);
    chk("rsp_entry", rsp_entry, e_ent);
    chk("rsp_line", rsp_line, e_line);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_hit", rsp_hit, e_hit);
    chk("rsp_arvalid", arvalid, 1'b0);
  endtask

  // One complete lookup; expectations come from the buffer model above.
  task automatic run_req(input bit t, input int id, input bit inv_acc, input bit inv_r,
                         input logic [1:0] resp, input int ar_dly, input int r_dly,
                         input int rsp_dly, input logic [511:0] data);
    logic [511:0] e_ent, e_line;
    logic [63:0]  e_addr;
    bit           e_err, e_hit;
    int           lidx;
    chk("req_ready_idle", req_ready, 1'b1);
    lidx  = (id == 0) ? 0 : (id - 1) / epl(t);
    e_hit = (id != 0) && !inv_acc && m_vld[t] && (m_tag[t] == lidx);
    if (inv_acc) model_clear();
    req_valid = 1'b1; req_type = t; req_id = IW'(id); inv = inv_acc;
    tick();
    req_valid = 1'b0; inv = 1'b0; req_id = IW'($urandom);
    chk("req_ready_busy", req_ready, 1'b0);
    if (id == 0) begin
      e_err = 1'b1; e_hit = 1'b0; e_line = '0; e_ent = '0;
    end else if (e_hit) begin
      e_err = 1'b0; e_line = m_line[t]; e_ent = exp_entry(m_line[t], t, id);
    end else begin
      e_addr = (t ? LST_B : ATT_B) + 64'(lidx) * 64'd64;
      chk("arvalid", arvalid, 1'b1);
      chk("araddr", araddr, e_addr);
      chk("arlen", arlen, 8'd0);
      chk("miss_rsp_valid", rsp_valid, 1'b0);
      for (int i = 0; i < ar_dly; i++) begin
        tick();
        chk("arvalid_hold", arvalid, 1'b1);
        chk("araddr_hold", araddr, e_addr);
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("ar_done", arvalid, 1'b0);
      chk("rready", rready, 1'b1);
      for (int i = 0; i < r_dly; i++) begin
        tick();
        chk("rready_hold", rready, 1'b1);
        chk("r_rsp_valid", rsp_valid, 1'b0);
      end
      rvalid = 1'b1; rdata = data; rresp = resp; inv = inv_r;
      tick();
      rvalid = 1'b0; inv = 1'b0; rdata = rnd_line(); rresp = 2'(($urandom));
      e_hit = 1'b0; e_err = (resp != 2'b00); e_line = data; e_ent = exp_entry(data, t, id);
      if (inv_r) model_clear();
      else if (resp == 2'b00) begin
        m_vld[t] = 1'b1; m_tag[t] = lidx; m_line[t] = data;
      end else m_vld[t] = 1'b0;
      chk("r_done_rready", rready, 1'b0);
    end
    check_rsp(t, id, e_ent, e_line, e_err, e_hit);
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      check_rsp(t, id, e_ent, e_line, e_err, e_hit);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, arvalid, 1'b0);
    chk({tag, "_rready"}, rready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_rsp_hit"}, rsp_hit, 1'b0);
    chk({tag, "_araddr"}, araddr, '0);
    chk({tag, "_rsp_entry"}, rsp_entry, '0);
    chk({tag, "_rsp_line"}, rsp_line, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    rst_n = 1'b0; req_valid = 1'b0; req_type = 1'b0; req_id = '0; inv = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rsp_ready = 1'b0;
    model_clear();
    m_tag[0] = 0; m_tag[1] = 0; m_line[0] = '0; m_line[1] = '0;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_req_ready", req_ready, 1'b1);

    // ATT id 1 -> base address, entry from low 64 bits
    d = rnd_line(); d[63:0] = 64'hA5;
    run_req(1'b0, 1, 1'b0, 1'b0, 2'b00, 0, 0, 0, d);
    chk("att1_entry_a5", rsp_entry, 128'hA5);
    // ATT id 9 miss (second line), id 16 hit on slot 7
    run_req(1'b0, 9, 1'b0, 1'b0, 2'b00, 2, 1, 0, rnd_line());
    run_req(1'b0, 16, 1'b0, 1'b0, 2'b00, 0, 0, 0, rnd_line());
    // TOL id 5 miss, id 8 hit on slot 3
    run_req(1'b1, 5, 1'b0, 1'b0, 2'b00, 1, 2, 1, rnd_line());
    run_req(1'b1, 8, 1'b0, 1'b0, 2'b00, 0, 0, 0, rnd_line());
    // ATT buffer must still be intact (no aliasing with TOL)
    run_req(1'b0, 10, 1'b0, 1'b0, 2'b00, 0, 0, 0, rnd_line());
    // id 0 error
    run_req(1'b1, 0, 1'b0, 1'b0, 2'b00, 0, 0, 2, rnd_line());
    // SLVERR then same id misses again
    run_req(1'b1, 6, 1'b0, 1'b0, 2'b10, 0, 0, 0, rnd_line());
    run_req(1'b1, 6, 1'b0, 1'b0, 2'b00, 0, 0, 0, rnd_line());
    // fill, invalidate while idle, repeat -> miss; hold rsp 5 cycles
    run_req(1'b0, 2, 1'b0, 1'b0, 2'b00, 0, 0, 0, rnd_line());
    inv = 1'b1; tick(); inv = 1'b0; model_clear();
    run_req(1'b0, 2, 1'b0, 1'b0, 2'b00, 0, 0, 5, rnd_line());
    // invalidate coincident with accept, and with R capture
    run_req(1'b0, 3, 1'b1, 1'b0, 2'b00, 0, 0, 0, rnd_line());
    run_req(1'b0, 4, 1'b0, 1'b1, 2'b00, 0, 0, 0, rnd_line());
    run_req(1'b0, 4, 1'b0, 1'b0, 2'b00, 0, 0, 0, rnd_line());

    // reset in the middle of an R phase; late rvalid must be ignored
    req_valid = 1'b1; req_type = 1'b0; req_id = IW'(40);
    tick();
    req_valid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    tick();
    chk("pre_rst_rready", rready, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;
    rvalid = 1'b1; rdata = rnd_line();
    tick();
    rvalid = 1'b0;
    chk("late_r_rready", rready, 1'b0);
    chk("late_r_rsp_valid", rsp_valid, 1'b0);
    chk("late_r_req_ready", req_ready, 1'b1);
    run_req(1'b0, 4, 1'b0, 1'b0, 2'b00, 0, 0, 0, rnd_line());

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      bit         t, ia, ir;
      int         id;
      logic [1:0] rs;
      t  = 1'($urandom_range(0, 1));
      id = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 24));
      ia = ($urandom_range(0, 9) == 0);
      ir = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 15) == 0) begin
        inv = 1'b1; tick(); inv = 1'b0; model_clear();
      end
      if ($urandom_range(0, 3) == 0) tick();
      run_req(t, id, ia, ir, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), rnd_line());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
